// File: rtl/sram_pkg.sv
// Shared helpers for the line-wide SRAM pipeline: width math and byte-lane addressing.
package sram_pkg;

  localparam int unsigned ByteW = 8;

  function automatic int unsigned line_w(input int unsigned line_bytes);
    return ByteW * line_bytes;
  endfunction

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  // LSB position of byte lane `lane` inside a packed line
  function automatic int unsigned byte_lsb(input int unsigned lane);
    return ByteW * lane;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage; head entry is presented on rdata_o.
module sync_fifo
  import sram_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [clog2(DEPTH+1)-1:0]      count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int unsigned CntW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] ram_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = ram_q[rptr_q];

  // A push into a full FIFO is only honoured when a pop frees the slot this cycle
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = (wptr_q == PtrW'(DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = (rptr_q == PtrW'(DEPTH - 1)) ? '0 : rptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) ram_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sram_line_pipe.sv
// Line-wide byte-addressed SRAM with masked writes, a fixed-latency read pipeline,
// and a credit-protected response FIFO so backpressure never drops read data.
module sram_line_pipe
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [LINE_BYTES-1:0]         req_mask,
  input  logic [line_w(LINE_BYTES)-1:0] req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [line_w(LINE_BYTES)-1:0] resp_rdata,
  output logic                          busy
);

  localparam int unsigned LineW     = line_w(LINE_BYTES);
  localparam int unsigned CntW      = clog2(FIFO_DEPTH + 1);
  localparam int unsigned NumStages = (RD_LAT > 1) ? RD_LAT - 1 : 1;
  localparam int unsigned MemBytes  = 2 ** ADDR_W;

  logic [7:0]        mem_q [MemBytes];
  logic [ADDR_W-1:0] lane_idx [LINE_BYTES];
  logic [LineW-1:0]  rd_line, push_data, head;
  logic              accept, rd_fire, wr_fire, pop, push;
  logic              fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              unused_fifo;

  assign req_ready  = ~rst & (cnt_q < CntW'(FIFO_DEPTH));
  assign accept     = req_valid & req_ready;
  assign rd_fire    = accept & ~req_we;
  assign wr_fire    = accept & req_we;
  assign resp_valid = ~rst & ~fifo_empty;
  assign resp_rdata = resp_valid ? head : '0;
  assign pop        = resp_valid & resp_ready;
  assign busy       = ~rst & (cnt_q != '0);

  // Lane addresses wrap naturally at the ADDR_W boundary
  always_comb begin
    for (int unsigned i = 0; i < LINE_BYTES; i++) lane_idx[i] = req_addr + ADDR_W'(i);
  end

  always_comb begin
    rd_line = '0;
    for (int unsigned i = 0; i < LINE_BYTES; i++) rd_line[byte_lsb(i) +: 8] = mem_q[lane_idx[i]];
  end

  // Array contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int unsigned i = 0; i < LINE_BYTES; i++) begin
        if (req_mask[i]) mem_q[lane_idx[i]] <= req_wdata[byte_lsb(i) +: 8];
      end
    end
  end

  if (RD_LAT == 1) begin : g_no_stage
    assign push      = rd_fire;
    assign push_data = rd_line;
  end else begin : g_stage
    // Stage 0 samples the array at the accepting edge; the FIFO register adds the last cycle
    logic [LineW-1:0]     st_data_q [NumStages];
    logic [NumStages-1:0] st_vld_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        st_vld_q <= '0;
      end else begin
        st_vld_q[0] <= rd_fire;
        for (int unsigned s = 1; s < NumStages; s++) st_vld_q[s] <= st_vld_q[s-1];
      end
    end

    always_ff @(posedge clk) begin
      st_data_q[0] <= rd_line;
      for (int unsigned s = 1; s < NumStages; s++) st_data_q[s] <= st_data_q[s-1];
    end

    assign push      = st_vld_q[NumStages-1];
    assign push_data = st_data_q[NumStages-1];
  end

  sync_fifo #(
    .WIDTH (LineW),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign unused_fifo = ^{fifo_full, fifo_count};

  // Outstanding reads (pipeline + FIFO); capping at FIFO_DEPTH makes overflow impossible
  always_comb begin
    cnt_d = cnt_q;
    case ({rd_fire, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
